split_decode_stage: RTL and testbench
=====================================

SPLIT_DECODE_STAGE -- requirements
Module: split_decode_stage

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16: register and operand width.
REQ-002 The block SHALL take parameter ADDR_W, default 3: register address width, giving 2^ADDR_W registers.
REQ-003 The block SHALL take parameter INSTR_W, default 16: instruction word width; legal values satisfy INSTR_W >= 5+2*ADDR_W.
REQ-004 The block SHALL take parameter IMM_OPC, default 5'b11000: the opcode of a two-word instruction whose second word carries the immediate.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port instr_valid, input, 1 bit: fetch presents a word.
REQ-009 The block SHALL have port instr, input, INSTR_W bits: fields are opcode=[top 5], rs=next ADDR_W, rd=next ADDR_W.
REQ-010 The block SHALL have port instr_ready, output, 1 bit: the word is accepted when instr_valid and instr_ready are both high at a clock edge.
REQ-011 The block SHALL have port stall_in, input, 1 bit: load-use stall request.
REQ-012 The block SHALL have port flush_in, input, 1 bit: branch-taken flush request.
REQ-013 The block SHALL have port irq, input, 1 bit: interrupt request (level).
REQ-014 The block SHALL have port irq_ack, output, 1 bit: single-cycle acknowledge pulse.
REQ-015 The block SHALL have ports wb_en (input, 1), wb_addr (input, ADDR_W) and wb_data (input, DATA_W): register write-back.
REQ-016 The block SHALL have ports ex_valid (output, 1), ex_opcode (output, 5), ex_op1 (output, DATA_W), ex_op2 (output, DATA_W), ex_imm (output, DATA_W), ex_rd (output, ADDR_W) and ex_is_imm (output, 1): the registered ID/EX stage.

Function
REQ-017 The block SHALL hold a register file of 2^ADDR_W x DATA_W, written at the clock edge when wb_en is high.
REQ-018 The block SHALL compute instr_ready = !stall_in & !flush_in & (state != IRQ) & !irq_take, where irq_take is defined in REQ-024.
REQ-019 In IDLE, an accepted word with opcode != IMM_OPC SHALL load ID/EX on that edge: ex_valid=1, ex_op1=RF[rs], ex_op2=RF[rd], ex_rd=rd, ex_is_imm=0, ex_imm=0. Latency is 1 cycle.
REQ-020 In IDLE, an accepted word with opcode == IMM_OPC SHALL capture opcode, rs, rd and both operands, move the FSM to IMM_WAIT, and set ex_valid=0.
REQ-021 In IMM_WAIT, the next accepted word SHALL become ex_imm (low DATA_W bits, zero-extended if INSTR_W < DATA_W), with ex_valid=1 and ex_is_imm=1, and the FSM SHALL return to IDLE.
REQ-022 In IMM_WAIT with no accepted word, the FSM SHALL hold state and set ex_valid=0.
REQ-023 Stall SHALL have this effect: while stall_in=1 and flush_in=0, no word is accepted, the FSM holds, and ID/EX loads a bubble (ex_valid=0, other ex_* fields unchanged).
REQ-024 Interrupt: irq_take = irq & (state==IDLE) & !stall_in & !flush_in. When irq_take=1, the FSM SHALL enter IRQ, a bubble SHALL be issued, and irq_ack=1 for exactly that one following cycle; the FSM then returns to IDLE.
REQ-025 An irq arriving in IMM_WAIT SHALL be deferred until the second word completes.
REQ-026 Flush SHALL have this effect: flush_in=1 forces ex_valid=0 on the next edge, aborts IMM_WAIT to IDLE (discarding the captured first word), and accepts no word; flush dominates stall and irq.
REQ-027 Precedence SHALL be rst > flush_in > stall_in > irq_take > normal accept.
REQ-028 Register reads SHALL be combinational from the RF and registered into ID/EX; ex_* fields SHALL be held unchanged whenever they are not loaded.

Reset
REQ-029 On a clock edge with rst=1: FSM=IDLE, all RF entries=0, ex_valid=0, every ex_* field=0, irq_ack=0.
REQ-030 instr_ready SHALL be 0 while rst=1.
REQ-031 Reset during IMM_WAIT or IRQ SHALL discard the partial instruction and SHALL suppress any pending irq_ack.

Configuration
REQ-032 The macro SPLIT_DECODE_BYPASS_EN SHALL control write-through bypass.
REQ-033 When SPLIT_DECODE_BYPASS_EN is defined: if wb_en=1 and wb_addr equals rs (or rd) in the accepting cycle, the corresponding operand SHALL be wb_data.
REQ-034 When SPLIT_DECODE_BYPASS_EN is undefined: the operand SHALL be the pre-write RF value, and the hazard unit covers that case.

Verification
REQ-035 Reset then single op: rst 1 cycle; write RF[2]=0x1234 and RF[5]=0x00FF; accept opcode 00001, rs=2, rd=5 -> next cycle ex_valid=1, ex_op1=0x1234, ex_op2=0x00FF, ex_rd=5.
REQ-036 Two-word: accept IMM_OPC with rd=3, then word 0xBEEF -> ex_valid=0 after word 1; after word 2, ex_valid=1, ex_is_imm=1, ex_imm=0xBEEF, ex_rd=3.
REQ-037 Stall: stall_in=1 for 2 cycles with instr_valid=1 -> instr_ready=0, ex_valid=0 for 2 cycles; the held word issues on the cycle after stall_in falls.
REQ-038 Flush mid-immediate: IMM_OPC accepted, then flush_in=1 -> FSM=IDLE, ex_valid=0; the next word 0x0800 decodes as a fresh instruction (opcode 00001), not as an immediate.
REQ-039 Interrupt: irq=1 in IDLE -> irq_ack=1 for exactly 1 cycle, one bubble is issued, instr_ready=0 that cycle; irq raised in IMM_WAIT -> irq_ack only after the second word issues.
REQ-040 Bypass: wb_en=1, wb_addr=4, wb_data=0xA5A5 in the same cycle as accepting rs=4 (RF[4]=0) -> ex_op1=0xA5A5 with SPLIT_DECODE_BYPASS_EN defined, 0x0000 without it.

Source files
------------

// File: rtl/split_decode_stage.sv
// Decode stage with a register file, two-word immediate instructions, stall/flush/irq handling.
// Optional write-through bypass of the write-back port is enabled by defining SPLIT_DECODE_BYPASS_EN.
module split_decode_stage #(
  parameter int         DATA_W  = 16,
  parameter int         ADDR_W  = 3,
  parameter int         INSTR_W = 16,
  parameter logic [4:0] IMM_OPC = 5'b11000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               irq,
  output logic               irq_ack,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               ex_valid,
  output logic [4:0]         ex_opcode,
  output logic [DATA_W-1:0]  ex_op1,
  output logic [DATA_W-1:0]  ex_op2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ADDR_W-1:0]  ex_rd,
  output logic               ex_is_imm
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, IMM_WAIT, IRQ} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] rf [NREGS];

  logic [4:0]        f_opcode;
  logic [ADDR_W-1:0] f_rs, f_rd;
  logic [DATA_W-1:0] rd_op1, rd_op2, imm_word;

  logic [4:0]        pend_opcode;
  logic [ADDR_W-1:0] pend_rd;
  logic [DATA_W-1:0] pend_op1, pend_op2;

  logic irq_take, accept, load_plain, load_imm, capture;

  assign f_opcode = instr[INSTR_W-1 -: 5];
  assign f_rs     = instr[INSTR_W-6 -: ADDR_W];
  assign f_rd     = instr[INSTR_W-6-ADDR_W -: ADDR_W];

  generate
    if (INSTR_W >= DATA_W) begin : g_imm_trunc
      assign imm_word = instr[DATA_W-1:0];
    end else begin : g_imm_zext
      assign imm_word = {{(DATA_W-INSTR_W){1'b0}}, instr};
    end
  endgenerate

`ifdef SPLIT_DECODE_BYPASS_EN
  assign rd_op1 = (wb_en && wb_addr == f_rs) ? wb_data : rf[f_rs];
  assign rd_op2 = (wb_en && wb_addr == f_rd) ? wb_data : rf[f_rd];
`else
  // Same-cycle write-back hazards are resolved upstream; read the pre-write value.
  assign rd_op1 = rf[f_rs];
  assign rd_op2 = rf[f_rd];
`endif

  assign irq_take    = irq && (state == IDLE) && !stall_in && !flush_in;
  assign instr_ready = !rst && !stall_in && !flush_in && (state != IRQ) && !irq_take;
  assign accept      = instr_valid && instr_ready;
  assign irq_ack     = (state == IRQ);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    load_plain = 1'b0;
    load_imm   = 1'b0;
    capture    = 1'b0;
    // The IRQ state always lasts exactly one cycle so the acknowledge is a single pulse.
    if (flush_in || state == IRQ) begin
      state_nxt = IDLE;
    end else if (stall_in) begin
      state_nxt = state;
    end else if (irq_take) begin
      state_nxt = IRQ;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (f_opcode == IMM_OPC) begin
            capture   = 1'b1;
            state_nxt = IMM_WAIT;
          end else begin
            load_plain = 1'b1;
          end
        end
        IMM_WAIT: begin
          load_imm  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      // NOTE: the register file is architecturally required to clear on reset, so it is built from flops.
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      ex_valid    <= 1'b0;
      ex_opcode   <= '0;
      ex_op1      <= '0;
      ex_op2      <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_is_imm   <= 1'b0;
      pend_opcode <= '0;
      pend_rd     <= '0;
      pend_op1    <= '0;
      pend_op2    <= '0;
    end else begin
      state <= state_nxt;
      if (wb_en) rf[wb_addr] <= wb_data;

      ex_valid <= load_plain || load_imm;

      if (capture) begin
        pend_opcode <= f_opcode;
        pend_rd     <= f_rd;
        pend_op1    <= rd_op1;
        pend_op2    <= rd_op2;
      end

      if (load_plain) begin
        ex_opcode <= f_opcode;
        ex_op1    <= rd_op1;
        ex_op2    <= rd_op2;
        ex_rd     <= f_rd;
        ex_imm    <= '0;
        ex_is_imm <= 1'b0;
      end else if (load_imm) begin
        ex_opcode <= pend_opcode;
        ex_op1    <= pend_op1;
        ex_op2    <= pend_op2;
        ex_rd     <= pend_rd;
        ex_imm    <= imm_word;
        ex_is_imm <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_split_decode_stage.sv
// Directed self-checking bench for split_decode_stage (default parameters).
// Expectations for the bypass case follow SPLIT_DECODE_BYPASS_EN as seen by this file.
module tb_split_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        stall_in, flush_in, irq, irq_ack;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid, ex_is_imm;
  logic [4:0]  ex_opcode;
  logic [15:0] ex_op1, ex_op2, ex_imm;
  logic [2:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  split_decode_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .stall_in(stall_in), .flush_in(flush_in), .irq(irq), .irq_ack(irq_ack),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_is_imm(ex_is_imm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; instr = 16'h0AA0;
    #1;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_checks++; if (ex_op1 !== 16'h0 || ex_op2 !== 16'h0 || ex_imm !== 16'h0) begin n_fail++; $display("FAIL reset_ops: got %h %h %h want 0 0 0", ex_op1, ex_op2, ex_imm); end
    n_checks++; if (ex_rd !== 3'd0 || ex_opcode !== 5'd0 || ex_is_imm !== 1'b0) begin n_fail++; $display("FAIL reset_fields: got rd=%0d opc=%0h imm=%b want 0", ex_rd, ex_opcode, ex_is_imm); end
    n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL reset_irq_ack: got %b want 0", irq_ack); end
    rst = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic test_single_op();
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234; step();
    wb_addr = 3'd5; wb_data = 16'h00FF; step();
    wb_en = 1'b0;
    instr_valid = 1'b1; instr = 16'h0AA0;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_is_imm !== 1'b0) begin n_fail++; $display("FAIL single_valid: got v=%b imm=%b want 1 0", ex_valid, ex_is_imm); end
    n_checks++; if (ex_op1 !== 16'h1234 || ex_op2 !== 16'h00FF) begin n_fail++; $display("FAIL single_ops: got %h %h want 1234 00ff", ex_op1, ex_op2); end
    n_checks++; if (ex_rd !== 3'd5 || ex_opcode !== 5'b00001 || ex_imm !== 16'h0) begin n_fail++; $display("FAIL single_fields: got rd=%0d opc=%b imm=%h want 5 00001 0", ex_rd, ex_opcode, ex_imm); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || ex_op1 !== 16'h1234) begin n_fail++; $display("FAIL single_hold: got v=%b op1=%h want 0 1234", ex_valid, ex_op1); end
  endtask

  task automatic test_two_word();
    instr_valid = 1'b1; instr = 16'hC260;
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL imm_first_valid: got %b want 0", ex_valid); end
    step();
    n_checks++; if (ex_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL imm_gap: got v=%b rdy=%b want 0 1", ex_valid, instr_ready); end
    instr_valid = 1'b1; instr = 16'hBEEF;
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_is_imm !== 1'b1) begin n_fail++; $display("FAIL imm_second_valid: got v=%b imm=%b want 1 1", ex_valid, ex_is_imm); end
    n_checks++; if (ex_imm !== 16'hBEEF || ex_rd !== 3'd3) begin n_fail++; $display("FAIL imm_value: got imm=%h rd=%0d want beef 3", ex_imm, ex_rd); end
    n_checks++; if (ex_opcode !== 5'b11000 || ex_op1 !== 16'h1234) begin n_fail++; $display("FAIL imm_captured: got opc=%b op1=%h want 11000 1234", ex_opcode, ex_op1); end
  endtask

  task automatic test_stall();
    stall_in = 1'b1; instr_valid = 1'b1; instr = 16'h0AA0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %b want 0", i, instr_ready); end
      step();
      n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_%0d: got %b want 0", i, ex_valid); end
    end
    stall_in = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_op2 !== 16'h00FF || ex_is_imm !== 1'b0) begin n_fail++; $display("FAIL stall_issue: got v=%b op2=%h imm=%b want 1 00ff 0", ex_valid, ex_op2, ex_is_imm); end
  endtask

  task automatic test_flush();
    instr_valid = 1'b1; instr = 16'hC260;
    step();
    flush_in = 1'b1; instr = 16'h0800;
    #1;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", instr_ready); end
    step();
    flush_in = 1'b0;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_is_imm !== 1'b0 || ex_opcode !== 5'b00001) begin n_fail++; $display("FAIL flush_fresh: got v=%b imm=%b opc=%b want 1 0 00001", ex_valid, ex_is_imm, ex_opcode); end
    n_checks++; if (ex_rd !== 3'd0 || ex_op1 !== 16'h0 || ex_imm !== 16'h0) begin n_fail++; $display("FAIL flush_fields: got rd=%0d op1=%h imm=%h want 0 0 0", ex_rd, ex_op1, ex_imm); end
  endtask

  task automatic test_irq();
    irq = 1'b1; instr_valid = 1'b1; instr = 16'h0AA0;
    #1;
    n_checks++; if (instr_ready !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_take: got rdy=%b ack=%b want 0 0", instr_ready, irq_ack); end
    step();
    irq = 1'b0;
    n_checks++; if (irq_ack !== 1'b1 || ex_valid !== 1'b0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL irq_pulse: got ack=%b v=%b rdy=%b want 1 0 0", irq_ack, ex_valid, instr_ready); end
    step();
    n_checks++; if (irq_ack !== 1'b0 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL irq_single: got ack=%b v=%b want 0 0", irq_ack, ex_valid); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 3'd5) begin n_fail++; $display("FAIL irq_resume: got v=%b rd=%0d want 1 5", ex_valid, ex_rd); end
    // Interrupt raised while waiting for an immediate word
    instr_valid = 1'b1; instr = 16'hC260;
    step();
    instr_valid = 1'b0; irq = 1'b1;
    #1;
    n_checks++; if (instr_ready !== 1'b1 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_deferred: got rdy=%b ack=%b want 1 0", instr_ready, irq_ack); end
    step();
    n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_wait_ack: got %b want 0", irq_ack); end
    instr_valid = 1'b1; instr = 16'h1234;
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_imm !== 16'h1234 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_imm_issue: got v=%b imm=%h ack=%b want 1 1234 0", ex_valid, ex_imm, irq_ack); end
    step();
    irq = 1'b0;
    n_checks++; if (irq_ack !== 1'b1 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL irq_late_ack: got ack=%b v=%b want 1 0", irq_ack, ex_valid); end
    step();
    n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_late_single: got %b want 0", irq_ack); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_op1;
`ifdef SPLIT_DECODE_BYPASS_EN
    exp_op1 = 16'hA5A5;
`else
    exp_op1 = 16'h0000;
`endif
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'hA5A5;
    instr_valid = 1'b1; instr = 16'h0CA0;
    step();
    wb_en = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_op1 !== exp_op1 || ex_op2 !== 16'h00FF) begin n_fail++; $display("FAIL bypass_same_cycle: got v=%b op1=%h op2=%h want 1 %h 00ff", ex_valid, ex_op1, ex_op2, exp_op1); end
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_op1 !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_written: got %h want a5a5", ex_op1); end
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; instr = 16'hC260;
    step();
    instr_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (ex_valid !== 1'b0 || ex_op1 !== 16'h0) begin n_fail++; $display("FAIL rstmid_clear: got v=%b op1=%h want 0 0", ex_valid, ex_op1); end
    instr_valid = 1'b1; instr = 16'hBEEF;
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_valid !== 1'b1 || ex_is_imm !== 1'b0 || ex_opcode !== 5'b10111 || ex_rd !== 3'd7) begin n_fail++; $display("FAIL rstmid_fresh: got v=%b imm=%b opc=%b rd=%0d want 1 0 10111 7", ex_valid, ex_is_imm, ex_opcode, ex_rd); end
    instr_valid = 1'b1; instr = 16'h0AA0;
    step();
    instr_valid = 1'b0;
    n_checks++; if (ex_op1 !== 16'h0 || ex_op2 !== 16'h0) begin n_fail++; $display("FAIL rstmid_rf_cleared: got %h %h want 0 0", ex_op1, ex_op2); end
    irq = 1'b1;
    step();
    irq = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_irq_ready: got %b want 0", instr_ready); end
    step();
    rst = 1'b0;
    n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_irq_ack: got %b want 0", irq_ack); end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; stall_in = 1'b0; flush_in = 1'b0;
    irq = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #2;
    test_reset();
    test_single_op();
    test_two_word();
    test_stall();
    test_flush();
    test_irq();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
